// File: rtl/imsic_msi_ingress.sv
// MSI seteipnum write ingress: decodes bus writes into (hart, file, EIID) events and queues them in a FWFT FIFO.
// Optional macro IMSIC_SETEIPNUM_BE_EN enables big-endian seteipnum at page offset 4.
module imsic_msi_ingress #(
    parameter int NrHarts      = 4,
    parameter int NrGuestFiles = 2,
    parameter int NrSources    = 64,
    parameter int AddrW        = 32,
    parameter int DataW        = 32,
    parameter int FifoDepth    = 4,
    parameter logic [AddrW-1:0] MBaseAddr = 32'h2400_0000,
    parameter logic [AddrW-1:0] SBaseAddr = 32'h2800_0000,
    parameter int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    parameter int FileW = $clog2(NrGuestFiles + 2),
    parameter int SrcW  = $clog2(NrSources)
) (
    input  logic               i_clk,
    input  logic               ni_rst,
    input  logic               i_wvalid,
    output logic               o_wready,
    input  logic [AddrW-1:0]   i_waddr,
    input  logic [DataW-1:0]   i_wdata,
    input  logic [DataW/8-1:0] i_wbe,
    output logic               o_wack,
    output logic               o_werr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [HartW-1:0]   o_hart,
    output logic [FileW-1:0]   o_file,
    output logic [SrcW-1:0]    o_eiid,
    output logic [15:0]        o_drop_cnt
);

    localparam int PerHartS = NrGuestFiles + 1;
    localparam int NrSPages = NrHarts * PerHartS;
    // One extra value of headroom so the per-hart divisor always fits in the page width.
    localparam int PageW = $clog2(NrSPages + 1);
    localparam int PtrW  = $clog2(FifoDepth);
    localparam int CntW  = $clog2(FifoDepth) + 1;
    localparam int EvW   = HartW + FileW + SrcW;

    localparam logic [AddrW-1:0] MSpan   = AddrW'(NrHarts * 4096);
    localparam logic [AddrW-1:0] SSpan   = AddrW'(NrSPages * 4096);
    localparam logic [PageW-1:0] GDiv    = PageW'(PerHartS);
    localparam logic [SrcW:0]    SrcLim  = (SrcW + 1)'(NrSources);
    localparam logic [DataW-1:0] ValMask = {{(DataW - SrcW){1'b0}}, {SrcW{1'b1}}};

    function automatic logic [DataW-1:0] byte_mask(input logic [DataW/8-1:0] be);
        logic [DataW-1:0] m;
        m = '0;
        for (int i = 0; i < DataW / 8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

`ifdef IMSIC_SETEIPNUM_BE_EN
    function automatic logic [31:0] byte_rev32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction
`endif

    logic [AddrW-1:0] off_m, off_s;
    logic             m_hit, s_hit;
    logic [HartW-1:0] page_m, s_hart, ev_hart;
    logic [PageW-1:0] page_s;
    logic [FileW-1:0] s_file, ev_file;
    logic [DataW-1:0] dmask;
    logic [SrcW-1:0]  val;
    logic             off_ok, be_ok, upper_ok, legal;
    logic             accept, push, pop;

    assign off_m  = i_waddr - MBaseAddr;
    assign off_s  = i_waddr - SBaseAddr;
    assign m_hit  = (i_waddr >= MBaseAddr) && (off_m < MSpan);
    assign s_hit  = (i_waddr >= SBaseAddr) && (off_s < SSpan);
    assign page_m = off_m[12 +: HartW];
    assign page_s = off_s[12 +: PageW];
    assign s_hart = HartW'(page_s / GDiv);
    assign s_file = FileW'(page_s % GDiv) + FileW'(1);
    assign dmask  = byte_mask(i_wbe);

    // M-level pages win if the two windows were ever configured to overlap.
    assign ev_hart = m_hit ? page_m : s_hart;
    assign ev_file = m_hit ? '0 : s_file;

`ifdef IMSIC_SETEIPNUM_BE_EN
    logic [31:0] be_word, be_dmask;
    assign be_word  = byte_rev32(i_wdata[31:0]);
    assign be_dmask = byte_rev32(dmask[31:0]);
`endif

    always_comb begin
        val      = '0;
        off_ok   = 1'b0;
        be_ok    = 1'b0;
        upper_ok = 1'b0;
        if (i_waddr[11:0] == 12'd0) begin
            val      = i_wdata[SrcW-1:0];
            off_ok   = 1'b1;
            be_ok    = i_wbe[0];
            upper_ok = ((i_wdata & dmask & ~ValMask) == '0);
        end
`ifdef IMSIC_SETEIPNUM_BE_EN
        else if (i_waddr[11:0] == 12'd4) begin
            val      = be_word[SrcW-1:0];
            off_ok   = 1'b1;
            be_ok    = i_wbe[0] && i_wbe[3];
            upper_ok = ((be_word & be_dmask & ~ValMask[31:0]) == '0);
        end
`endif
        legal = (m_hit || s_hit) && off_ok && be_ok && upper_ok &&
                (val != '0) && ({1'b0, val} < SrcLim);
    end

    logic [EvW-1:0]  mem [FifoDepth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;

    assign o_wready = (count < CntW'(FifoDepth));
    assign o_valid  = (count != '0);
    assign accept   = i_wvalid && o_wready;
    assign push     = accept && legal;
    assign pop      = o_valid && i_ready;
    assign {o_hart, o_file, o_eiid} = o_valid ? mem[rd_ptr] : '0;

    // Acceptance stage: event storage carries no reset, only control does.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {ev_hart, ev_file, val};
        end
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_wack     <= 1'b0;
            o_werr     <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_wack <= accept;
            o_werr <= accept && !legal;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (accept && !legal && (o_drop_cnt != 16'hFFFF)) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_imsic_msi_ingress.sv
// Scoreboard bench for imsic_msi_ingress: directed scenarios plus randomized writes against an address-map model.
module tb_imsic_msi_ingress;

    localparam int NH = 4;
    localparam int NG = 2;
    localparam int NS = 64;
    localparam int SW = 6;
    localparam longint MB = 64'h2400_0000;
    localparam longint SB = 64'h2800_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wbe = '0;
    logic        wack, werr, ovalid;
    logic        ready = 1'b0;
    logic [1:0]  hart;
    logic [1:0]  file;
    logic [5:0]  eiid;
    logic [15:0] drop_cnt;

    imsic_msi_ingress dut (
        .i_clk(clk), .ni_rst(rst_n), .i_wvalid(wvalid), .o_wready(wready),
        .i_waddr(waddr), .i_wdata(wdata), .i_wbe(wbe), .o_wack(wack), .o_werr(werr),
        .o_valid(ovalid), .i_ready(ready), .o_hart(hart), .o_file(file), .o_eiid(eiid),
        .o_drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int exp_drops = 0;
    int exp_ev_q[$];
    bit exp_err_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address-map reference: plain page arithmetic on the documented windows.
    function automatic void ref_decode(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                                       output bit ok, output int h, output int f, output int e);
        longint la, pg, off, v, vm, dm;
        bit hit, off_ok, be_ok;
        logic [31:0] sw;
        la = longint'(a);
        hit = 0; off_ok = 0; be_ok = 0; h = 0; f = 0; e = 0; v = 0; vm = 0; dm = 0;
        if (la >= MB && la < MB + NH * 4096) begin
            hit = 1; pg = (la - MB) / 4096; h = int'(pg); f = 0;
        end else if (la >= SB && la < SB + NH * (NG + 1) * 4096) begin
            hit = 1; pg = (la - SB) / 4096; h = int'(pg / (NG + 1)); f = int'(pg % (NG + 1)) + 1;
        end
        for (int i = 0; i < 4; i++) if (be[i]) dm |= longint'(255) << (8 * i);
        off = la % 4096;
        if (off == 0) begin
            off_ok = 1; be_ok = be[0]; v = longint'(d); vm = dm;
        end
`ifdef IMSIC_SETEIPNUM_BE_EN
        else if (off == 4) begin
            sw = {d[7:0], d[15:8], d[23:16], d[31:24]};
            off_ok = 1; be_ok = be[0] && be[3]; v = longint'(sw);
            vm = 0;
            for (int i = 0; i < 4; i++) if (be[3 - i]) vm |= longint'(255) << (8 * i);
        end
`endif
        e = int'(v % (1 << SW));
        ok = hit && off_ok && be_ok && (((v & vm) >> SW) == 0) && e > 0 && e < NS;
    endfunction

    // Monitor: compares acks and popped events against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wack) begin
                if (exp_err_q.size() == 0) chk("unexpected_wack", 1, 0);
                else chk("werr", werr, exp_err_q.pop_front());
            end
            if (ovalid && exp_ev_q.size() == 0) chk("unexpected_valid", 1, 0);
            else if (ovalid && ready) chk("event_hfe", {hart, file, eiid}, exp_ev_q.pop_front());
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bit ok;
        int h, f, e;
        wvalid = 1'b1; waddr = a; wdata = d; wbe = be;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (wready) begin
                ref_decode(a, d, be, ok, h, f, e);
                exp_err_q.push_back(!ok);
                if (ok) exp_ev_q.push_back((h << 8) | (f << 6) | e);
                else if (exp_drops < 65535) exp_drops++;
                @(posedge clk); #1;
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("write_accept_timeout", 0, 1);
        wvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        ready = 1'b1;
        n = 0;
        while ((exp_ev_q.size() != 0 || ovalid || exp_err_q.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        @(negedge clk);
        chk("drain_empty", exp_ev_q.size() + exp_err_q.size(), 0);
        chk("drain_valid", ovalid, 0);
        chk("drop_cnt", drop_cnt, exp_drops);
        @(posedge clk); #1;
    endtask

    bit rnd_done;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ovalid, 0);
        chk("rst_wack", wack, 0);
        chk("rst_werr", werr, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_head", {hart, file, eiid}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wready", wready, 1);
        @(posedge clk); #1;

        // M page 2 and S page 4 decode, 1-cycle latency
        do_write(32'h2400_2000, 32'd5, 4'h1);
        @(negedge clk);
        chk("latency_valid", ovalid, 1);
        @(posedge clk); #1;
        drain();
        do_write(32'h2800_4000, 32'd7, 4'hF);
        drain();

        // Illegal writes
        do_write(32'h2400_0000, 32'd0, 4'h1);
        do_write(32'h2400_0000, 32'd64, 4'h1);
        do_write(32'h2400_4000, 32'd3, 4'h1);
        @(negedge clk);
        chk("illegal_valid", ovalid, 0);
        @(posedge clk); #1;
        drain();
        chk("drop_cnt3", drop_cnt, 3);

        // Backpressure: 4 fill the FIFO, the 5th waits for one pop
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) do_write(32'h2400_1000, 32'(i + 10), 4'h1);
        @(negedge clk);
        chk("full_wready", wready, 0);
        @(posedge clk); #1;
        fork
            do_write(32'h2800_1000, 32'd20, 4'h1);
            begin
                repeat (3) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("refill_wready", wready, 0);
        @(posedge clk); #1;
        drain();

        // Simultaneous push and pop at count 3
        ready = 1'b0;
        for (int i = 0; i < 3; i++) do_write(32'h2400_3000, 32'(30 + i), 4'h1);
        ready = 1'b1;
        do_write(32'h2800_2000, 32'd40, 4'h1);
        ready = 1'b0;
        @(negedge clk);
        chk("pushpop_wready", wready, 1);
        @(posedge clk); #1;
        do_write(32'h2400_0000, 32'd41, 4'h1);
        @(negedge clk);
        chk("pushpop_full", wready, 0);
        @(posedge clk); #1;
        drain();

        // Big-endian offset
        do_write(32'h2400_0004, 32'h0900_0000, 4'hF);
        drain();

        // Reset while events and an ack are pending
        ready = 1'b0;
        do_write(32'h2400_1000, 32'd9, 4'h1);
        do_write(32'h2400_1000, 32'd0, 4'h1);
        rst_n = 1'b0;
        exp_ev_q.delete();
        exp_err_q.delete();
        exp_drops = 0;
        @(negedge clk);
        chk("midrst_valid", ovalid, 0);
        chk("midrst_wack", wack, 0);
        chk("midrst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random consumer stalls
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [31:0] a, d;
                    logic [3:0] be;
                    int k, o;
                    k = $urandom_range(0, 4);
                    o = $urandom_range(0, 5);
                    if (k <= 1)      a = 32'(MB + $urandom_range(0, NH) * 4096);
                    else if (k <= 3) a = 32'(SB + $urandom_range(0, NH * (NG + 1)) * 4096);
                    else             a = $urandom;
                    if (o == 3) a[11:0] = 12'd4;
                    else if (o == 4) a[11:0] = 12'd8;
                    else if (o == 5) a[11:0] = 12'($urandom);
                    else a[11:0] = 12'd0;
                    case ($urandom_range(0, 3))
                        0:       d = $urandom;
                        1:       d = {$urandom_range(0, 70) & 32'hFF, 24'h0};
                        default: d = $urandom_range(0, 70);
                    endcase
                    be = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                    do_write(a, d, be);
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imsic_msi_ingress.md
Name: imsic_msi_ingress

Overview:
- Parametrised MSI write ingress for the IMSIC.
- Decodes memory-mapped seteipnum writes into (hart, interrupt file, EIID) events for any number of harts and guest files per hart.
- Filters illegal writes and buffers legal events in a first-word-fall-through FIFO with valid/ready backpressure toward the interrupt-file array.
- Sits between the bus protocol converter and the per-hart interrupt files.

Parameters:
- NrHarts, 4, number of harts; HartW = max(1, $clog2(NrHarts)).
- NrGuestFiles, 2, VS files per hart; files per hart = NrGuestFiles+2 (0=M, 1=S, 2..=guests); FileW = $clog2(NrGuestFiles+2).
- NrSources, 64, interrupt identities per file (EIID 1..NrSources-1 legal); SrcW = $clog2(NrSources).
- AddrW, 32, bus address width.
- DataW, 32, bus write data width (>= SrcW).
- FifoDepth, 4, event FIFO entries (>= 2, power of two).
- MBaseAddr, 32'h2400_0000, base of M-level pages, one 4 KiB page per hart.
- SBaseAddr, 32'h2800_0000, base of S/guest pages, (NrGuestFiles+1) consecutive 4 KiB pages per hart.

Ports:
- i_clk, input, 1, clock.
- ni_rst, input, 1, asynchronous active-low reset.
- i_wvalid, input, 1, bus write request.
- o_wready, output, 1, write accepted when i_wvalid && o_wready.
- i_waddr, input, AddrW, write byte address.
- i_wdata, input, DataW, write data.
- i_wbe, input, DataW/8, byte enables.
- o_wack, output, 1, one-cycle pulse the cycle after each accepted write.
- o_werr, output, 1, valid with o_wack; 1 = write discarded.
- o_valid, output, 1, event available at FIFO head.
- i_ready, input, 1, consumer takes head when o_valid && i_ready.
- o_hart, output, HartW, target hart.
- o_file, output, FileW, target interrupt file.
- o_eiid, output, SrcW, identity to set pending.
- o_drop_cnt, output, 16, saturating count of discarded writes.

Behaviour:
- Reset (async, ni_rst=0):
  - FIFO empty; o_valid=0; o_wack=0; o_werr=0; o_drop_cnt=0.
  - o_hart/o_file/o_eiid=0; o_wready=1 after reset release.
- o_wready = (count < FifoDepth). Derived from registered count only; no combinational path from i_ready.
- Decode of an accepted write; page = (addr - base) >> 12, offset = addr[11:0]:
  - M range: MBaseAddr <= addr < MBaseAddr + NrHarts*4096 -> hart = page, file = 0.
  - S range: SBaseAddr <= addr < SBaseAddr + NrHarts*(NrGuestFiles+1)*4096 -> hart = page/(NrGuestFiles+1), file = page%(NrGuestFiles+1)+1.
  - Division and modulo operate on page width only; constant divisor.
  - offset 0 = seteipnum_le: value = i_wdata[SrcW-1:0], with upper data bits required zero.
- A write is legal only if all of the following hold; otherwise it is discarded:
  - address in either range;
  - offset legal;
  - i_wbe[0] = 1;
  - 0 < value < NrSources;
  - no nonzero bits in i_wdata above SrcW within the enabled bytes.
- Legal write: pushes {hart, file, eiid} into the FIFO in the acceptance cycle; o_wack=1, o_werr=0 next cycle.
- Illegal write:
  - no push; o_wack=1, o_werr=1 next cycle;
  - o_drop_cnt increments and saturates at 16'hFFFF.
- FIFO behaviour:
  - first-word fall-through: head visible on o_hart/o_file/o_eiid while o_valid=1; outputs are held stable until popped;
  - push and pop in the same cycle leave count unchanged, including when count = FifoDepth-1 or count = 1;
  - pop on empty is ignored;
  - pointers wrap modulo FifoDepth.
- Latency: legal write to o_valid = 1 cycle when the FIFO is empty.
- Ordering: events leave in acceptance order.
- Duplicate EIIDs are forwarded; no coalescing.
- Reset mid-operation discards all buffered events and the pending o_wack.

Optional Feature:
- Macro: IMSIC_SETEIPNUM_BE_EN.
- Defined:
  - offset 4 in any page is seteipnum_be;
  - the value is the 32-bit byte-reversed i_wdata, i.e. {d[7:0], d[15:8], d[23:16], d[31:24]};
  - legality requires i_wbe[3] = 1 when the write is at offset 4; other legality rules are unchanged.
- Undefined: offset 4 is illegal and the write is dropped with o_werr.

Test Plan:
- Write 32'd5 to MBaseAddr+32'h2000 -> next cycle o_wack=1, o_werr=0; o_valid=1 with hart=2, file=0, eiid=5.
- NrGuestFiles=2, write 32'd7 to SBaseAddr+32'h4000 (page 4) -> hart=1, file=2, eiid=7.
- Write eiid 0, then eiid 64, then to MBaseAddr+NrHarts*4096 -> three o_werr=1 pulses; o_drop_cnt=3; o_valid stays 0.
- i_ready=0 with 5 legal writes -> o_wready drops after the 4th; the 5th is stalled until one pop, then accepted; output order matches input order.
- FIFO at count 3, push and pop in the same cycle -> count stays 3; head advances by one entry.
- With IMSIC_SETEIPNUM_BE_EN, write 32'h0900_0000 to MBaseAddr+4 -> eiid=9. Without the macro -> o_werr=1.
